// File: rtl/johnson_counter_param_pkg.sv
// ---------------------------------------------------------------------------
// johnson_counter_param_pkg
// Shared types for the Johnson counter slice.
//   dir_e : step direction. DIR_UP walks the forward (up) sequence and
//           DIR_DOWN walks the same sequence in reverse.
// ---------------------------------------------------------------------------
package johnson_counter_param_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage : johnson_counter_param_pkg

// File: rtl/johnson_phase_decode.sv
// ---------------------------------------------------------------------------
// johnson_phase_decode
// Pure combinational decoder for one Johnson code word.
//   code  : WIDTH-bit candidate Johnson code
//   phase : binary index of code in the up sequence (0 when illegal)
//   legal : 1 when at most one adjacent bit pair differs
// The up sequence is a top-aligned run of ones that grows (phase 0..WIDTH)
// and is then eaten from the top by a run of zeros (phase WIDTH+1..2W-1).
// ---------------------------------------------------------------------------
module johnson_phase_decode #(
  parameter  int WIDTH = 4,
  localparam int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic [PW-1:0]    phase,
  output logic             legal
);

  int unsigned edges;
  int unsigned ones;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned, which is what would otherwise infer a latch.
    edges = 0;
    ones  = 0;
    phase = '0;
    legal = 1'b0;

    for (int i = 0; i < WIDTH - 1; i++) begin
      edges = edges + 32'(code[i] ^ code[i+1]);
    end
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + 32'(code[i]);
    end

    legal = (edges <= 1);

    if (legal) begin
      // A set MSB (or all-zeros) means the ones run is still growing; a
      // clear MSB with some ones means the zeros run is taking over.
      if (code[WIDTH-1] || ones == 0) begin
        phase = PW'(ones);
      end else begin
        phase = PW'(2 * WIDTH - ones);
      end
    end
  end

endmodule : johnson_phase_decode

// File: rtl/johnson_counter_param.sv
// ---------------------------------------------------------------------------
// johnson_counter_param
// Parametrised Johnson (twisted-ring) counter with a 2*WIDTH-state sequence.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   en       : advance one step this cycle
//   dir      : 0 = up (forward), 1 = down (reverse)
//   load     : synchronous parallel load (overrides en/dir)
//   load_val : value loaded when load=1
//   dout     : registered counter state
//   phase    : registered binary index of dout in the up sequence
//   illegal  : dout is not a legal Johnson code (combinational)
//   tc       : this enabled step wraps the sequence (combinational)
// The phase register tracks dout incrementally; only a load re-decodes.
// ---------------------------------------------------------------------------
module johnson_counter_param
  import johnson_counter_param_pkg::*;
#(
  parameter  int WIDTH        = 4,
  parameter  bit SELF_CORRECT = 1'b1,
  localparam int PW           = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic [PW-1:0]    phase,
  output logic             illegal,
  output logic             tc
);

  localparam logic [PW-1:0] PHASE_FIRST = '0;
  localparam logic [PW-1:0] PHASE_LAST  = PW'(2 * WIDTH - 1);

  logic [PW-1:0]    load_phase;
  logic             load_legal;
  logic [PW-1:0]    dout_phase_unused;
  logic             dout_legal;
  logic [WIDTH-1:0] up_code;
  logic [WIDTH-1:0] down_code;
  logic [WIDTH-1:0] shift_code;
  logic             going_down;

  johnson_phase_decode #(.WIDTH(WIDTH)) u_load_decode (
    .code  (load_val),
    .phase (load_phase),
    .legal (load_legal)
  );

  // Only legality is needed for dout; phase comes from the register.
  johnson_phase_decode #(.WIDTH(WIDTH)) u_dout_decode (
    .code  (dout),
    .phase (dout_phase_unused),
    .legal (dout_legal)
  );

  assign going_down = (dir_e'(dir) == DIR_DOWN);
  assign up_code    = {~dout[0], dout[WIDTH-1:1]};
  assign down_code  = {dout[WIDTH-2:0], ~dout[WIDTH-1]};
  assign shift_code = going_down ? down_code : up_code;
  assign illegal    = ~dout_legal;

  // Gated by reset_n so tc reads low while reset is held even if en/dir
  // would otherwise select the wrap condition at phase 0.
  assign tc = reset_n & en & ~load & ~illegal &
              ((~going_down & (phase == PHASE_LAST)) |
               ( going_down & (phase == PHASE_FIRST)));

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout  <= '0;
      phase <= PHASE_FIRST;
    end else if (load) begin
      dout  <= load_val;
      phase <= load_legal ? load_phase : PHASE_FIRST;
    end else if (en && illegal) begin
      dout  <= SELF_CORRECT ? '0 : shift_code;
      phase <= PHASE_FIRST;
    end else if (en) begin
      dout <= shift_code;
      if (going_down) begin
        phase <= (phase == PHASE_FIRST) ? PHASE_LAST : phase - 1'b1;
      end else begin
        phase <= (phase == PHASE_LAST) ? PHASE_FIRST : phase + 1'b1;
      end
    end
  end

endmodule : johnson_counter_param
